// File: rtl/sdc_init_ctrl.sv
// SD-card SPI-mode initialisation sequencer: drives CMD0, CMD8, CMD55/ACMD41 and CMD16
// through a single-command SPI engine and reports ready/error to the transfer logic.
module sdc_init_ctrl #(
    parameter int PWR_CYCLES   = 16,
    parameter int CMD0_RETRY   = 8,
    parameter int ACMD41_RETRY = 255,
    parameter int TIMEOUT      = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    output logic [7:0]  o_cmd,
    output logic [31:0] o_arg,
    output logic [7:0]  o_crc,
    output logic        o_we,
    input  logic        i_done,
    input  logic [7:0]  i_res,
    output logic        o_busy,
    output logic        o_ready,
    output logic        o_v2,
    output logic        o_err,
    output logic [2:0]  o_err_code
);

    typedef enum logic [2:0] {
        S_IDLE, S_PWR, S_ISSUE, S_WAIT, S_EVAL, S_DONE, S_ERR
    } state_t;

    typedef enum logic [2:0] {
        ST_CMD0, ST_CMD8, ST_CMD55, ST_ACMD41, ST_CMD16
    } step_t;

    state_t      state_q;
    step_t       step_q;
    logic [15:0] pwr_cnt_q;
    logic [15:0] tmo_cnt_q;
    logic [7:0]  cmd0_cnt_q;
    logic [7:0]  acmd_cnt_q;
    logic [7:0]  res_q;
    logic [7:0]  o_cmd_q;
    logic [31:0] o_arg_q;
    logic [7:0]  o_crc_q;
    logic        o_we_q;
    logic        o_busy_q;
    logic        o_ready_q;
    logic        o_v2_q;
    logic        o_err_q;
    logic [2:0]  o_err_code_q;

    step_t       ev_step_d;
    logic        ev_v2_d;
    logic        ev_done_d;
    logic        ev_err_d;
    logic [2:0]  ev_code_d;
    logic [7:0]  cmd0_cnt_d;
    logic [7:0]  acmd_cnt_d;
    step_t       issue_step_d;
    logic [7:0]  enc_cmd_d;
    logic [31:0] enc_arg_d;
    logic [7:0]  enc_crc_d;

    // Decision taken on the captured R1 response; only consumed while in S_EVAL.
    always_comb begin
        ev_step_d  = step_q;
        ev_v2_d    = o_v2_q;
        ev_done_d  = 1'b0;
        ev_err_d   = 1'b0;
        ev_code_d  = 3'd0;
        cmd0_cnt_d = cmd0_cnt_q;
        acmd_cnt_d = acmd_cnt_q;
        case (step_q)
            ST_CMD0: begin
                if (res_q == 8'h01) begin
                    ev_step_d = ST_CMD8;
                end else begin
                    cmd0_cnt_d = cmd0_cnt_q + 8'd1;
                    if (cmd0_cnt_d == 8'(CMD0_RETRY)) begin
                        ev_err_d  = 1'b1;
                        ev_code_d = 3'd1;
                    end
                end
            end
            ST_CMD8: begin
                if (res_q == 8'h01) begin
                    ev_v2_d   = 1'b1;
                    ev_step_d = ST_CMD55;
                end else if (res_q[2]) begin
                    ev_v2_d   = 1'b0;
                    ev_step_d = ST_CMD55;
                end else begin
                    ev_err_d  = 1'b1;
                    ev_code_d = 3'd2;
                end
            end
            ST_CMD55: begin
                if (res_q == 8'h00 || res_q == 8'h01) begin
                    ev_step_d = ST_ACMD41;
                end else begin
                    ev_err_d  = 1'b1;
                    ev_code_d = 3'd4;
                end
            end
            ST_ACMD41: begin
                if (res_q == 8'h00) begin
                    if (o_v2_q) ev_done_d = 1'b1;
                    else        ev_step_d = ST_CMD16;
                end else if (res_q == 8'h01) begin
                    acmd_cnt_d = acmd_cnt_q + 8'd1;
                    if (acmd_cnt_d == 8'(ACMD41_RETRY)) begin
                        ev_err_d  = 1'b1;
                        ev_code_d = 3'd3;
                    end else begin
                        ev_step_d = ST_CMD55;
                    end
                end else begin
                    ev_err_d  = 1'b1;
                    ev_code_d = 3'd4;
                end
            end
            ST_CMD16: begin
                if (res_q == 8'h00) begin
                    ev_done_d = 1'b1;
                end else begin
                    ev_err_d  = 1'b1;
                    ev_code_d = 3'd5;
                end
            end
            default: begin
                ev_step_d = ST_CMD0;
            end
        endcase
    end

    // The power-up path always launches CMD0; otherwise the post-evaluation step is launched.
    always_comb begin
        issue_step_d = (state_q == S_EVAL) ? ev_step_d : ST_CMD0;
        enc_cmd_d    = 8'h40;
        enc_arg_d    = 32'h0000_0000;
        enc_crc_d    = 8'h95;
        case (issue_step_d)
            ST_CMD8: begin
                enc_cmd_d = 8'h48;
                enc_arg_d = 32'h0000_01AA;
                enc_crc_d = 8'h87;
            end
            ST_CMD55: begin
                enc_cmd_d = 8'h77;
                enc_crc_d = 8'h01;
            end
            ST_ACMD41: begin
                enc_cmd_d = 8'h69;
                enc_arg_d = ev_v2_d ? 32'h4000_0000 : 32'h0000_0000;
                enc_crc_d = 8'h01;
            end
            ST_CMD16: begin
                enc_cmd_d = 8'h50;
                enc_arg_d = 32'h0000_0200;
                enc_crc_d = 8'h01;
            end
            default: begin
                enc_cmd_d = 8'h40;
                enc_arg_d = 32'h0000_0000;
                enc_crc_d = 8'h95;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            step_q       <= ST_CMD0;
            pwr_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
            cmd0_cnt_q   <= '0;
            acmd_cnt_q   <= '0;
            res_q        <= '0;
            o_cmd_q      <= '0;
            o_arg_q      <= '0;
            o_crc_q      <= '0;
            o_we_q       <= 1'b0;
            o_busy_q     <= 1'b0;
            o_ready_q    <= 1'b0;
            o_v2_q       <= 1'b0;
            o_err_q      <= 1'b0;
            o_err_code_q <= '0;
        end else begin
            o_we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (i_start) begin
                        o_ready_q    <= 1'b0;
                        o_err_q      <= 1'b0;
                        o_err_code_q <= '0;
                        o_v2_q       <= 1'b0;
                        cmd0_cnt_q   <= '0;
                        acmd_cnt_q   <= '0;
                        pwr_cnt_q    <= '0;
                        o_busy_q     <= 1'b1;
                        step_q       <= ST_CMD0;
                        state_q      <= S_PWR;
                    end
                end
                S_PWR: begin
                    if (pwr_cnt_q == 16'(PWR_CYCLES - 1)) begin
                        o_we_q  <= 1'b1;
                        o_cmd_q <= enc_cmd_d;
                        o_arg_q <= enc_arg_d;
                        o_crc_q <= enc_crc_d;
                        state_q <= S_ISSUE;
                    end else begin
                        pwr_cnt_q <= pwr_cnt_q + 16'd1;
                    end
                end
                S_ISSUE: begin
                    tmo_cnt_q <= '0;
                    state_q   <= S_WAIT;
                end
                S_WAIT: begin
                    // A response arriving on the expiring cycle still counts.
                    if (i_done) begin
                        res_q   <= i_res;
                        state_q <= S_EVAL;
                    end else if (tmo_cnt_q + 16'd1 == 16'(TIMEOUT - 1)) begin
                        o_busy_q     <= 1'b0;
                        o_err_q      <= 1'b1;
                        o_err_code_q <= 3'd6;
                        state_q      <= S_ERR;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    end
                end
                S_EVAL: begin
                    step_q     <= ev_step_d;
                    o_v2_q     <= ev_v2_d;
                    cmd0_cnt_q <= cmd0_cnt_d;
                    acmd_cnt_q <= acmd_cnt_d;
                    if (ev_err_d) begin
                        o_busy_q     <= 1'b0;
                        o_err_q      <= 1'b1;
                        o_err_code_q <= ev_code_d;
                        state_q      <= S_ERR;
                    end else if (ev_done_d) begin
                        o_busy_q  <= 1'b0;
                        o_ready_q <= 1'b1;
                        state_q   <= S_DONE;
                    end else begin
                        o_we_q  <= 1'b1;
                        o_cmd_q <= enc_cmd_d;
                        o_arg_q <= enc_arg_d;
                        o_crc_q <= enc_crc_d;
                        state_q <= S_ISSUE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_cmd      = o_cmd_q;
    assign o_arg      = o_arg_q;
    assign o_crc      = o_crc_q;
    assign o_we       = o_we_q;
    assign o_busy     = o_busy_q;
    assign o_ready    = o_ready_q;
    assign o_v2       = o_v2_q;
    assign o_err      = o_err_q;
    assign o_err_code = o_err_code_q;

endmodule
